// File: rtl/video_scale_ds_if.sv
`default_nettype none
// ============================================================================
//  Module   : video_scale_ds_if
//  Purpose  : Video stream, run-time config and packed write-port bundle for
//             the capture-path downscaler.
//  Revision : 1.0  initial release
// ============================================================================
interface video_scale_ds_if #(
   parameter int DW    = 8,
   parameter int NCH   = 3,
   parameter int OUT_W = 32
);
   logic                vs_in;
   logic                hs_in;
   logic                de_in;
   logic [NCH*DW-1:0]   pix_in;
   logic [15:0]         cfg_in_xres;
   logic [31:0]         cfg_x_step;
   logic [31:0]         cfg_y_step;
   logic                cfg_mode;
   logic                vs_out;
   logic                hs_out;
   logic                de_out;
   logic [OUT_W-1:0]    wr_data;
   logic                sof_out;
   logic                eol_out;

   // Upstream timing stage / config source side
   modport master (
      output vs_in, hs_in, de_in, pix_in,
      output cfg_in_xres, cfg_x_step, cfg_y_step, cfg_mode,
      input  vs_out, hs_out, de_out, wr_data, sof_out, eol_out
   );

   // Scaler side
   modport slave (
      input  vs_in, hs_in, de_in, pix_in,
      input  cfg_in_xres, cfg_x_step, cfg_y_step, cfg_mode,
      output vs_out, hs_out, de_out, wr_data, sof_out, eol_out
   );
endinterface
`default_nettype wire

// File: rtl/video_scale_ds.sv
`default_nettype none
// ============================================================================
//  Module   : video_scale_ds
//  Purpose  : Nearest-neighbour / horizontal 2-tap-average video downscaler.
//             16.16 step accumulators pick which input pixels and rows are
//             kept; output is a registered, write-enable-qualified word.
//  Revision : 1.0  initial release
// ============================================================================
module video_scale_ds #(
   parameter int DW    = 8,
   parameter int NCH   = 3,
   parameter int OUT_W = 32
) (
   input  wire logic        pixclk_in,
   input  wire logic        rst_n,
   video_scale_ds_if.slave  bus
);
   localparam int          c_PIX_W    = NCH * DW;
   localparam logic [31:0] c_STEP_ONE = 32'h0001_0000;

   logic               r_vs_d;
   logic               r_de_d;
   logic [15:0]        r_in_xres;
   logic [31:0]        r_x_step;
   logic [31:0]        r_y_step;
   logic               r_mode;
   logic [15:0]        r_vin_x;
   logic [15:0]        r_vin_y;
   logic [31:0]        r_x_acc;
   logic [31:0]        r_y_acc;
   logic [c_PIX_W-1:0] r_prev;

   logic               w_vs_rise;
   logic               w_de_fall;
   logic               w_row_keep;
   logic               w_keep;
   logic [31:0]        w_x_step;
   logic [31:0]        w_y_step;
   logic [c_PIX_W-1:0] w_prev;
   logic [c_PIX_W-1:0] w_filt;
   logic [OUT_W-1:0]   w_pack;

   // Sync-edge history and shadow config, captured once at frame start
   always_ff @(posedge pixclk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_d    <= 1'b0;
         r_de_d    <= 1'b0;
         r_in_xres <= 16'd0;
         r_x_step  <= 32'd0;
         r_y_step  <= 32'd0;
         r_mode    <= 1'b0;
      end else begin
         r_vs_d <= bus.vs_in;
         r_de_d <= bus.de_in;
         if (w_vs_rise) begin
            r_in_xres <= bus.cfg_in_xres;
            r_x_step  <= bus.cfg_x_step;
            r_y_step  <= bus.cfg_y_step;
            r_mode    <= bus.cfg_mode;
         end
      end
   end

   // Strobes, step clamp (never upscale) and the keep decision for this pixel
   always_comb begin
      w_vs_rise  = bus.vs_in & ~r_vs_d;
      w_de_fall  = ~bus.de_in & r_de_d;
      w_x_step   = (r_x_step < c_STEP_ONE) ? c_STEP_ONE : r_x_step;
      w_y_step   = (r_y_step < c_STEP_ONE) ? c_STEP_ONE : r_y_step;
      w_row_keep = (r_vin_y == r_y_acc[31:16]);
      w_keep     = bus.de_in & ~bus.vs_in & w_row_keep &
                   (r_vin_x == r_x_acc[31:16]) & (r_vin_x < r_in_xres);
      // First pixel of a line averages with itself
      w_prev     = (r_vin_x == 16'd0) ? bus.pix_in : r_prev;
   end

   // Input position counters and 16.16 sampling accumulators; vsync wins
   always_ff @(posedge pixclk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_vin_x <= 16'd0;
         r_vin_y <= 16'd0;
         r_x_acc <= 32'd0;
         r_y_acc <= 32'd0;
      end else if (bus.vs_in) begin
         r_vin_x <= 16'd0;
         r_vin_y <= 16'd0;
         r_x_acc <= 32'd0;
         r_y_acc <= 32'd0;
      end else if (w_de_fall) begin
         r_vin_x <= 16'd0;
         r_x_acc <= 32'd0;
         r_vin_y <= r_vin_y + 16'd1;
         if (w_row_keep) begin
            r_y_acc <= r_y_acc + w_y_step;
         end
      end else if (bus.de_in) begin
         r_vin_x <= r_vin_x + 16'd1;
         if (w_keep) begin
            r_x_acc <= r_x_acc + w_x_step;
         end
      end
   end

   // Remember the last valid input pixel for the 2-tap filter
   always_ff @(posedge pixclk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= '0;
      end else if (bus.de_in && !bus.vs_in) begin
         r_prev <= bus.pix_in;
      end
   end

   // Per-channel average with a carry bit so 255+255 cannot overflow
   generate
      for (genvar g = 0; g < NCH; g++) begin : g_ch
         logic [DW-1:0] w_avg;
         logic          w_unused_lsb;
         assign {w_avg, w_unused_lsb} = {1'b0, bus.pix_in[g*DW +: DW]} +
                                        {1'b0, w_prev[g*DW +: DW]};
         assign w_filt[g*DW +: DW] = r_mode ? w_avg : bus.pix_in[g*DW +: DW];
      end
      if (OUT_W > c_PIX_W) begin : g_pad
         assign w_pack = {{(OUT_W-c_PIX_W){1'b0}}, w_filt};
      end else begin : g_nopad
         assign w_pack = w_filt;
      end
   endgenerate

   // Registered outputs, one cycle behind the inputs
   always_ff @(posedge pixclk_in or negedge rst_n) begin
      if (!rst_n) begin
         bus.vs_out  <= 1'b0;
         bus.hs_out  <= 1'b0;
         bus.de_out  <= 1'b0;
         bus.wr_data <= '0;
         bus.sof_out <= 1'b0;
         bus.eol_out <= 1'b0;
      end else begin
         bus.vs_out  <= bus.vs_in;
         bus.hs_out  <= bus.hs_in;
         bus.de_out  <= w_keep;
         bus.wr_data <= w_keep ? w_pack : '0;
         bus.sof_out <= w_vs_rise;
         bus.eol_out <= w_de_fall;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_video_scale_ds.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_scale_ds
//  Purpose  : Self-checking bench for video_scale_ds. A frame-level model
//             derives the sampled positions from the step rules and predicts
//             every written word.
//  Revision : 1.0  initial release
// ============================================================================
module tb_video_scale_ds;
   localparam int DW    = 8;
   localparam int NCH   = 3;
   localparam int OUT_W = 32;
   localparam int PW    = NCH * DW;

   logic pixclk_in = 1'b0;
   logic rst_n     = 1'b0;

   video_scale_ds_if #(.DW(DW), .NCH(NCH), .OUT_W(OUT_W)) bus ();

   video_scale_ds #(.DW(DW), .NCH(NCH), .OUT_W(OUT_W)) dut (
      .pixclk_in (pixclk_in),
      .rst_n     (rst_n),
      .bus       (bus)
   );

   always #5 pixclk_in = ~pixclk_in;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge pixclk_in) cyc <= cyc + 1;

   // Output monitor: cumulative records, sampled mid-cycle
   logic [OUT_W-1:0] act_q[$];
   int               act_cyc[$];
   int               n_eol = 0, n_sof = 0, n_zero_bad = 0;
   int               sof_cyc = -1, vsr_cyc = -1;
   logic             vs_out_d = 1'b0;

   always @(negedge pixclk_in) begin
      if (bus.de_out === 1'b1) begin
         act_q.push_back(bus.wr_data);
         act_cyc.push_back(cyc);
      end else if (bus.wr_data !== '0) begin
         n_zero_bad++;
      end
      if (bus.eol_out === 1'b1) n_eol++;
      if (bus.sof_out === 1'b1) begin
         n_sof++;
         sof_cyc = cyc;
      end
      if (bus.vs_out === 1'b1 && vs_out_d !== 1'b1) vsr_cyc = cyc;
      vs_out_d = bus.vs_out;
   end

   // Model results for the most recent frame
   logic [OUT_W-1:0] exp_q[$];
   logic [PW-1:0]    pix_src[$];
   int               act_base, eol_base, sof_base;
   int               first_in_cyc, vs_drive_cyc;

   task automatic drive(input logic vs, input logic hs, input logic de, input logic [PW-1:0] pix);
      @(posedge pixclk_in);
      #1;
      bus.vs_in  = vs;
      bus.hs_in  = hs;
      bus.de_in  = de;
      bus.pix_in = pix;
   endtask

   // Drive one frame and build the expected output list.
   // w0 > 0 overrides the width of line 0.
   task automatic run_frame(input int w, input int h, input int xres,
                            input logic [31:0] xs, input logic [31:0] ys,
                            input logic mode, input int w0);
      bit               kx [0:1023];
      bit               ky [0:1023];
      longint           pos;
      logic [31:0]      xsc, ysc, r;
      logic [PW-1:0]    cur, prv;
      logic [OUT_W-1:0] e;
      int               len, a, b, v;
      exp_q.delete();
      act_base = act_q.size();
      eol_base = n_eol;
      sof_base = n_sof;
      prv      = '0;
      // Sampled columns/rows are floor(k*step) for k = 0,1,2,...
      xsc = (xs < 32'h0001_0000) ? 32'h0001_0000 : xs;
      ysc = (ys < 32'h0001_0000) ? 32'h0001_0000 : ys;
      foreach (kx[i]) kx[i] = 1'b0;
      foreach (ky[i]) ky[i] = 1'b0;
      pos = 0;
      while ((pos >> 16) < longint'(xres)) begin
         kx[int'(pos >> 16)] = 1'b1;
         pos += longint'(xsc);
      end
      pos = 0;
      while ((pos >> 16) < longint'(h)) begin
         ky[int'(pos >> 16)] = 1'b1;
         pos += longint'(ysc);
      end

      bus.cfg_in_xres = 16'(xres);
      bus.cfg_x_step  = xs;
      bus.cfg_y_step  = ys;
      bus.cfg_mode    = mode;
      r = $urandom();
      drive(1'b1, 1'b0, 1'b1, r[PW-1:0]);        // de coincident with vs
      vs_drive_cyc = cyc;
      drive(1'b1, 1'b0, 1'b0, '0);
      // Mid-frame config churn must be ignored
      r = $urandom();
      bus.cfg_x_step  = 32'h0000_8000;
      bus.cfg_y_step  = $urandom();
      bus.cfg_in_xres = r[31:16];
      bus.cfg_mode    = ~mode;
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, '0);

      for (int y = 0; y < h; y++) begin
         drive(1'b0, 1'b1, 1'b0, '0);
         drive(1'b0, 1'b0, 1'b0, '0);
         drive(1'b0, 1'b0, 1'b0, '0);
         len = (y == 0 && w0 > 0) ? w0 : w;
         for (int x = 0; x < len; x++) begin
            if (pix_src.size() > 0) cur = pix_src.pop_front();
            else begin
               r   = $urandom();
               cur = r[PW-1:0];
            end
            if (ky[y] && kx[x]) begin
               e = '0;
               for (int c = 0; c < NCH; c++) begin
                  a = int'(cur[c*DW +: DW]);
                  b = (x == 0) ? a : int'(prv[c*DW +: DW]);
                  v = mode ? (a + b) / 2 : a;
                  e[c*DW +: DW] = v[DW-1:0];
               end
               exp_q.push_back(e);
            end
            drive(1'b0, 1'b0, 1'b1, cur);
            if (y == 0 && x == 0) first_in_cyc = cyc;
            prv = cur;
         end
         for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, '0);
      end
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic test_reset();
      int base;
      logic [31:0] r;
      // Reset state while inputs are busy
      drive(1'b1, 1'b1, 1'b1, 24'hABCDEF);
      drive(1'b1, 1'b1, 1'b1, 24'h123456);
      #2;
      checks++; if (bus.vs_out !== 1'b0)  begin errors++; $display("FAIL reset_vs_out got=%b exp=0", bus.vs_out); end
      checks++; if (bus.hs_out !== 1'b0)  begin errors++; $display("FAIL reset_hs_out got=%b exp=0", bus.hs_out); end
      checks++; if (bus.de_out !== 1'b0)  begin errors++; $display("FAIL reset_de_out got=%b exp=0", bus.de_out); end
      checks++; if (bus.wr_data !== '0)   begin errors++; $display("FAIL reset_wr_data got=%h exp=0", bus.wr_data); end
      checks++; if (bus.sof_out !== 1'b0) begin errors++; $display("FAIL reset_sof_out got=%b exp=0", bus.sof_out); end
      checks++; if (bus.eol_out !== 1'b0) begin errors++; $display("FAIL reset_eol_out got=%b exp=0", bus.eol_out); end
      drive(1'b0, 1'b0, 1'b0, '0);
      rst_n = 1'b1;
      // Start a 1:1 frame, then reset in the middle of a line
      bus.cfg_in_xres = 16'd16;
      bus.cfg_x_step  = 32'h0001_0000;
      bus.cfg_y_step  = 32'h0001_0000;
      bus.cfg_mode    = 1'b0;
      drive(1'b1, 1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 6; i++) begin
         r = $urandom();
         drive(1'b0, 1'b0, 1'b1, r[PW-1:0] | 24'h1);
      end
      checks++; if (bus.de_out !== 1'b1) begin errors++; $display("FAIL pre_reset_de_out got=%b exp=1", bus.de_out); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (bus.de_out !== 1'b0) begin errors++; $display("FAIL async_reset_de_out got=%b exp=0", bus.de_out); end
      checks++; if (bus.wr_data !== '0)  begin errors++; $display("FAIL async_reset_wr_data got=%h exp=0", bus.wr_data); end
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 24'h5A5A5A);
      #2;
      checks++; if (bus.de_out !== 1'b0) begin errors++; $display("FAIL held_reset_de_out got=%b exp=0", bus.de_out); end
      rst_n = 1'b1;
      // Zero config until the next vsync: nothing may be written
      base = act_q.size();
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 24'h777777);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 24'h333333);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (act_q.size() !== base) begin
         errors++; $display("FAIL post_reset_no_output got=%0d writes exp=0", act_q.size() - base);
      end
   endtask

   task automatic test_decimation();
      logic [OUT_W-1:0] got;
      run_frame(96, 54, 96, 32'h0002_0000, 32'h0002_0000, 1'b0, 0);
      checks++;
      if (act_q.size() - act_base !== 48 * 27) begin
         errors++; $display("FAIL dec_count got=%0d exp=%0d", act_q.size() - act_base, 48 * 27);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (act_base + i < act_q.size()) ? act_q[act_base + i] : 'x;
         checks++;
         if (got !== exp_q[i]) begin errors++; $display("FAIL dec_data[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
      checks++;
      if (act_q.size() <= act_base || act_cyc[act_base] !== first_in_cyc + 1) begin
         errors++; $display("FAIL dec_latency got=%0d exp=%0d", (act_q.size() > act_base) ? act_cyc[act_base] : -1, first_in_cyc + 1);
      end
      checks++; if (n_eol - eol_base !== 55) begin errors++; $display("FAIL dec_eol_count got=%0d exp=55", n_eol - eol_base); end
      checks++; if (n_sof - sof_base !== 1)  begin errors++; $display("FAIL dec_sof_count got=%0d exp=1", n_sof - sof_base); end
      checks++; if (sof_cyc !== vs_drive_cyc + 1) begin errors++; $display("FAIL dec_sof_time got=%0d exp=%0d", sof_cyc, vs_drive_cyc + 1); end
      checks++; if (vsr_cyc !== sof_cyc) begin errors++; $display("FAIL dec_vs_out_rise got=%0d exp=%0d", vsr_cyc, sof_cyc); end
   endtask

   task automatic test_fractional();
      int kept_ref[8] = '{0, 1, 3, 4, 6, 7, 9, 10};
      logic [OUT_W-1:0] got;
      for (int l = 0; l < 4; l++)
         for (int x = 0; x < 12; x++) pix_src.push_back(PW'(x));
      run_frame(12, 4, 12, 32'h0001_8000, 32'h0001_0000, 1'b0, 0);
      checks++;
      if (act_q.size() - act_base !== 32) begin
         errors++; $display("FAIL frac_count got=%0d exp=32", act_q.size() - act_base);
      end
      for (int i = 0; i < 32; i++) begin
         got = (act_base + i < act_q.size()) ? act_q[act_base + i] : 'x;
         checks++;
         if (got !== OUT_W'(kept_ref[i % 8])) begin
            errors++; $display("FAIL frac_xpos[%0d] got=%h exp=%h", i, got, OUT_W'(kept_ref[i % 8]));
         end
      end
   endtask

   task automatic test_average();
      logic [OUT_W-1:0] got;
      logic [OUT_W-1:0] ref_v[4] = '{32'd10, 32'd25, 32'd0, 32'h00FF_FFFF};
      pix_src.push_back(24'd10);
      pix_src.push_back(24'd20);
      pix_src.push_back(24'd30);
      pix_src.push_back(24'd40);
      pix_src.push_back(24'h000000);
      pix_src.push_back(24'hFFFFFF);
      pix_src.push_back(24'hFFFFFF);
      pix_src.push_back(24'h000000);
      run_frame(4, 2, 4, 32'h0002_0000, 32'h0001_0000, 1'b1, 0);
      checks++;
      if (act_q.size() - act_base !== 4) begin
         errors++; $display("FAIL avg_count got=%0d exp=4", act_q.size() - act_base);
      end
      for (int i = 0; i < 4; i++) begin
         got = (act_base + i < act_q.size()) ? act_q[act_base + i] : 'x;
         checks++;
         if (got !== ref_v[i]) begin errors++; $display("FAIL avg_data[%0d] got=%h exp=%h", i, got, ref_v[i]); end
      end
   endtask

   task automatic test_config_latch();
      logic [OUT_W-1:0] got;
      run_frame(16, 4, 16, 32'h0002_0000, 32'h0001_0000, 1'b0, 0);
      checks++;
      if (act_q.size() - act_base !== 32) begin
         errors++; $display("FAIL latch_frame_a_count got=%0d exp=32", act_q.size() - act_base);
      end
      run_frame(16, 4, 16, 32'h0000_8000, 32'h0000_8000, 1'b0, 0);
      checks++;
      if (act_q.size() - act_base !== 64) begin
         errors++; $display("FAIL clamp_frame_b_count got=%0d exp=64", act_q.size() - act_base);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (act_base + i < act_q.size()) ? act_q[act_base + i] : 'x;
         checks++;
         if (got !== exp_q[i]) begin errors++; $display("FAIL clamp_data[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
   endtask

   task automatic test_short_line();
      logic [OUT_W-1:0] got;
      run_frame(120, 3, 960, 32'h0001_0000, 32'h0001_0000, 1'b0, 100);
      checks++;
      if (act_q.size() - act_base !== 340) begin
         errors++; $display("FAIL short_count got=%0d exp=340", act_q.size() - act_base);
      end
      checks++; if (n_eol - eol_base !== 4) begin errors++; $display("FAIL short_eol got=%0d exp=4", n_eol - eol_base); end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (act_base + i < act_q.size()) ? act_q[act_base + i] : 'x;
         checks++;
         if (got !== exp_q[i]) begin errors++; $display("FAIL short_data[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
   endtask

   task automatic test_random();
      logic [OUT_W-1:0] got;
      int w, h, xr;
      logic [31:0] xs, ys;
      for (int f = 0; f < 4; f++) begin
         w  = $urandom_range(8, 40);
         h  = $urandom_range(4, 12);
         xr = $urandom_range(0, w + 4);
         xs = 32'h0000_8000 + $urandom_range(0, 32'h0003_0000);
         ys = 32'h0000_8000 + $urandom_range(0, 32'h0003_0000);
         run_frame(w, h, xr, xs, ys, 1'($urandom_range(0, 1)), 0);
         checks++;
         if (act_q.size() - act_base !== exp_q.size()) begin
            errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", f, act_q.size() - act_base, exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            got = (act_base + i < act_q.size()) ? act_q[act_base + i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL rand%0d_data[%0d] got=%h exp=%h", f, i, got, exp_q[i]); end
         end
      end
      checks++;
      if (n_zero_bad !== 0) begin
         errors++; $display("FAIL idle_wr_data_zero got=%0d nonzero cycles exp=0", n_zero_bad);
      end
   endtask

   initial begin
      bus.vs_in       = 1'b0;
      bus.hs_in       = 1'b0;
      bus.de_in       = 1'b0;
      bus.pix_in      = '0;
      bus.cfg_in_xres = 16'd0;
      bus.cfg_x_step  = 32'd0;
      bus.cfg_y_step  = 32'd0;
      bus.cfg_mode    = 1'b0;
      test_reset();
      test_decimation();
      test_fractional();
      test_average();
      test_config_latch();
      test_short_line();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
